// File: rtl/gps_bridge_pkg.sv
// Shared types and constants for the GPS-to-MCU SPI bridge.
// Holds the serializer state encoding and the frame header sync byte.
package gps_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

endpackage

// File: rtl/gps_sample_fifo.sv
// Synchronous word FIFO. The head word is readable while not empty and is taken on the pop edge.
// Latency: a pushed word is visible one cycle later. A push while full is accepted only together with a pop.
module gps_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign rd_en = pop && !empty;
  // Popping in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        level <= level + 1'b1;
      end else if (!wr_en && rd_en) begin
        level <= level - 1'b1;
      end
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);

endmodule

// File: rtl/gps_spi_bridge_fifo.sv
// Packs GPS sample groups into words, buffers them and streams them MSB-first over gated-clock SPI while DATAREADY is high.
// Strobe to FIFO entry 1 cycle, pop to first SCK 1 cycle; a full FIFO drops words (sticky OVERFLOW). GPS_BRIDGE_FRAME_HEADER_EN adds a per-burst header word.
module gps_spi_bridge_fifo
  import gps_bridge_pkg::*;
#(
  parameter int SAMPLE_W   = 4,
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SS_DELAY   = 2,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                MCU_CLK_25_000,
  input  logic                RESET_N,
  input  logic [SAMPLE_W-1:0] GPS_DATA,
  input  logic                SAMPLE_STB,
  input  logic                SELF_TEST,
  input  logic                DATAREADY,
  output logic                MCU_SCK,
  output logic                MCU_SS,
  output logic                MCU_MOSI,
  output logic                OVERFLOW,
  output logic [LVL_W-1:0]    FIFO_LEVEL
);

  localparam int N_SMP = WORD_W / SAMPLE_W;
  localparam int CNT_W = (N_SMP > 1) ? $clog2(N_SMP) : 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int GAP_W = $clog2(SS_DELAY + 1);

  logic [SAMPLE_W-1:0] st_cnt;
  logic [SAMPLE_W-1:0] sample;
  logic [WORD_W-1:0]   pack_reg;
  logic [WORD_W-1:0]   pack_nxt;
  logic [CNT_W-1:0]    pack_cnt;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WORD_W-1:0]   fifo_head;

  assign sample   = SELF_TEST ? st_cnt : GPS_DATA;
  assign pack_nxt = (pack_reg << SAMPLE_W) | WORD_W'(sample);
  assign push     = SAMPLE_STB && (pack_cnt == CNT_W'(N_SMP - 1));

  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      st_cnt   <= '0;
      pack_reg <= '0;
      pack_cnt <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (SAMPLE_STB) begin
        st_cnt   <= st_cnt + 1'b1;
        pack_reg <= pack_nxt;
        pack_cnt <= push ? '0 : pack_cnt + 1'b1;
      end
      if (push && fifo_full && !pop) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  gps_sample_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (MCU_CLK_25_000),
    .rst_n    (RESET_N),
    .push     (push),
    .push_dat (pack_nxt),
    .pop      (pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (FIFO_LEVEL)
  );

  ser_state_t        state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              sck_en, sck_en_nxt;
  logic              ss_nxt;
  logic              start;

  assign start = DATAREADY && !fifo_empty;

`ifdef GPS_BRIDGE_FRAME_HEADER_EN
  logic [7:0]        seq, seq_nxt;
  logic [WORD_W-1:0] hdr_word;

  assign hdr_word = WORD_W'({HDR_SYNC, seq}) << (WORD_W - 16);
`endif

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sck_en_nxt  = sck_en;
    ss_nxt      = 1'b0;
    pop         = 1'b0;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
    seq_nxt     = seq;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          sck_en_nxt  = 1'b1;
          bit_cnt_nxt = '0;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
          shreg_nxt   = hdr_word;
          seq_nxt     = seq + 1'b1;
`else
          shreg_nxt   = fifo_head;
          pop         = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == BIT_W'(WORD_W - 1)) begin
          bit_cnt_nxt = '0;
          if (start) begin
            shreg_nxt = fifo_head;
            pop       = 1'b1;
          end else begin
            state_nxt   = GAP;
            sck_en_nxt  = 1'b0;
            shreg_nxt   = '0;
            gap_cnt_nxt = '0;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          shreg_nxt   = shreg << 1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(SS_DELAY - 1)) begin
          ss_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sck_en  <= 1'b0;
      MCU_SS  <= 1'b0;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
      seq     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sck_en  <= sck_en_nxt;
      MCU_SS  <= ss_nxt;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
      seq     <= seq_nxt;
`endif
    end
  end

  // SCK is high in the second half of each bit cycle, so the MCU samples mid-bit.
  assign MCU_SCK  = ~MCU_CLK_25_000 & sck_en;
  assign MCU_MOSI = shreg[WORD_W-1];

endmodule

// File: tb/tb_gps_spi_bridge_fifo.sv
// Directed and randomized bench for gps_spi_bridge_fifo against a queue-based model of packed words.
// A passive monitor reassembles SPI words on each SCK high phase.
module tb_gps_spi_bridge_fifo;

  localparam int SS_DELAY = 2;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
  localparam int HB = 16;
`else
  localparam int HB = 0;
`endif

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] GPS_DATA = '0;
  logic       SAMPLE_STB = 1'b0;
  logic       SELF_TEST = 1'b0;
  logic       DATAREADY = 1'b0;
  logic       MCU_SCK, MCU_SS, MCU_MOSI, OVERFLOW;
  logic [3:0] FIFO_LEVEL;

  gps_spi_bridge_fifo #(
    .SAMPLE_W(4), .WORD_W(16), .FIFO_DEPTH(8), .SS_DELAY(SS_DELAY)
  ) dut (
    .MCU_CLK_25_000 (clk),
    .RESET_N        (RESET_N),
    .GPS_DATA       (GPS_DATA),
    .SAMPLE_STB     (SAMPLE_STB),
    .SELF_TEST      (SELF_TEST),
    .DATAREADY      (DATAREADY),
    .MCU_SCK        (MCU_SCK),
    .MCU_SS         (MCU_SS),
    .MCU_MOSI       (MCU_MOSI),
    .OVERFLOW       (OVERFLOW),
    .FIFO_LEVEL     (FIFO_LEVEL)
  );

  always #20 clk = ~clk;

  // Monitor: only this process writes these.
  int          cyc, sck_total, sck_starts, burst_bits, ss_pulses, ss_high, ss_cyc, last_sck_cyc;
  logic        prev_sck = 1'b0, prev_ss = 1'b0;
  logic [15:0] rx_word;
  logic [15:0] rx_words [$];
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
  logic [15:0] hdr_words [$];
`endif

  always @(negedge clk) begin
    #1;
    cyc++;
    if (MCU_SCK === 1'b1) begin
      if (!prev_sck) begin
        sck_starts++;
        burst_bits = 0;
      end
      rx_word = {rx_word[14:0], MCU_MOSI};
      burst_bits++;
      sck_total++;
      last_sck_cyc = cyc;
      if (burst_bits % 16 == 0) begin
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
        if (burst_bits == 16) hdr_words.push_back(rx_word);
        else rx_words.push_back(rx_word);
`else
        rx_words.push_back(rx_word);
`endif
      end
    end
    if (MCU_SS === 1'b1) begin
      ss_high++;
      if (!prev_ss) begin
        ss_pulses++;
        ss_cyc = cyc;
      end
    end
    prev_sck = (MCU_SCK === 1'b1);
    prev_ss  = (MCU_SS === 1'b1);
  end

  // Reference model state and bookkeeping, owned by the stimulus process.
  int          errors, checks;
  logic [15:0] exp_words [$];
  int          exp_rd, rx_rd;
  logic [3:0]  st_model;
  logic [15:0] pack_acc;
  int          pack_n;
  logic        model_ovf;
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
  int          hdr_rd;
  logic [7:0]  hdr_seq;
`endif
  int          b_sck, b_starts, b_ss, b_ssh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return (exp_words.size() - exp_rd) - (rx_words.size() - rx_rd);
  endfunction

  task automatic strobe(input logic [3:0] gps, input logic st);
    logic [3:0] s;
    GPS_DATA   = gps;
    SELF_TEST  = st;
    SAMPLE_STB = 1'b1;
    s = st ? st_model : gps;
    st_model = st_model + 4'd1;
    pack_acc = {pack_acc[11:0], s};
    pack_n++;
    if (pack_n == 4) begin
      pack_n = 0;
      if (pending() < 8) exp_words.push_back(pack_acc);
      else model_ovf = 1'b1;
    end
    @(posedge clk); #1;
    SAMPLE_STB = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    RESET_N = 1'b0;
    repeat (n) @(posedge clk);
    #1 RESET_N = 1'b1;
    st_model  = '0;
    pack_acc  = '0;
    pack_n    = 0;
    model_ovf = 1'b0;
    exp_rd    = exp_words.size();
    rx_rd     = rx_words.size();
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
    hdr_seq   = '0;
    hdr_rd    = hdr_words.size();
`endif
  endtask

  task automatic snap();
    b_sck = sck_total; b_starts = sck_starts; b_ss = ss_pulses; b_ssh = ss_high;
  endtask

  task automatic wait_ss(input string tag, input int budget);
    int b = ss_pulses;
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (ss_pulses > b) ok = 1'b1;
    end
    chk({tag, "_ss_seen"}, 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input string tag, input int nbits, input int budget);
    int b = sck_starts;
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (sck_starts > b && burst_bits >= nbits) ok = 1'b1;
    end
    chk({tag, "_bits_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic check_words(input string tag, input int n);
    chk({tag, "_count"}, 32'(rx_words.size() - rx_rd), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (rx_rd < rx_words.size() && exp_rd < exp_words.size())
        chk({tag, "_word"}, 32'(rx_words[rx_rd]), 32'(exp_words[exp_rd]));
      rx_rd++;
      exp_rd++;
    end
  endtask

  task automatic check_hdrs(input string tag, input int n);
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
    chk({tag, "_hdr_count"}, 32'(hdr_words.size() - hdr_rd), 32'(n));
    for (int k = 0; k < n && hdr_rd < hdr_words.size(); k++) begin
      chk({tag, "_hdr"}, 32'(hdr_words[hdr_rd]), {16'h0, 8'hA5, hdr_seq});
      hdr_rd++;
      hdr_seq = hdr_seq + 8'd1;
    end
`else
    if (n < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    // Reset state
    do_reset(3);
    @(negedge clk); #1;
    chk("rst_sck", 32'(MCU_SCK), 0);
    chk("rst_ss", 32'(MCU_SS), 0);
    chk("rst_mosi", 32'(MCU_MOSI), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("rst_level", 32'(FIFO_LEVEL), 0);
    @(posedge clk); #1;

    // Self-test pattern, single word burst
    snap();
    DATAREADY = 1'b1;
    for (int i = 0; i < 4; i++) strobe(4'($urandom), 1'b1);
    wait_ss("t2", 200);
    chk("t2_expect_0123", 32'(exp_words[exp_rd]), 32'h0123);
    check_words("t2", 1);
    check_hdrs("t2", 1);
    chk("t2_sck_cycles", 32'(sck_total - b_sck), 32'(HB + 16));
    chk("t2_ss_delay", 32'(ss_cyc - last_sck_cyc), 32'(SS_DELAY + 1));
    chk("t2_ss_width", 32'(ss_high - b_ssh), 32'(ss_pulses - b_ss));

    // Eight queued words drained in one contiguous burst
    DATAREADY = 1'b0;
    for (int i = 0; i < 32; i++) strobe(4'($urandom), 1'b0);
    chk("t3_level_full", 32'(FIFO_LEVEL), 8);
    chk("t3_ovf", 32'(OVERFLOW), 32'(model_ovf));
    snap();
    DATAREADY = 1'b1;
    wait_ss("t3", 400);
    check_words("t3", 8);
    check_hdrs("t3", 1);
    chk("t3_sck_cycles", 32'(sck_total - b_sck), 32'(HB + 128));
    chk("t3_sck_starts", 32'(sck_starts - b_starts), 1);
    chk("t3_ss_pulses", 32'(ss_pulses - b_ss), 1);
    chk("t3_level_empty", 32'(FIFO_LEVEL), 0);

    // Nine words into a depth-8 FIFO with the MCU not ready
    DATAREADY = 1'b0;
    for (int i = 0; i < 36; i++) strobe(4'($urandom), 1'($urandom_range(0, 1)));
    chk("t4_level", 32'(FIFO_LEVEL), 8);
    chk("t4_ovf_model", 32'(model_ovf), 1);
    chk("t4_ovf", 32'(OVERFLOW), 32'(model_ovf));
    DATAREADY = 1'b1;
    wait_ss("t4", 400);
    check_words("t4", 8);
    check_hdrs("t4", 1);
    chk("t4_ovf_sticky", 32'(OVERFLOW), 1);
    chk("t4_level_empty", 32'(FIFO_LEVEL), 0);

    // DATAREADY dropped mid-word: word still completes
    DATAREADY = 1'b0;
    for (int i = 0; i < 8; i++) strobe(4'($urandom), 1'b0);
    snap();
    DATAREADY = 1'b1;
    wait_bits("t5", HB + 5, 100);
    DATAREADY = 1'b0;
    wait_ss("t5", 100);
    check_words("t5a", 1);
    check_hdrs("t5a", 1);
    chk("t5_sck_cycles", 32'(sck_total - b_sck), 32'(HB + 16));
    chk("t5_level", 32'(FIFO_LEVEL), 1);
    DATAREADY = 1'b1;
    wait_ss("t5b", 200);
    check_words("t5b", 1);
    check_hdrs("t5b", 1);

    // Reset mid-SHIFT
    DATAREADY = 1'b0;
    for (int i = 0; i < 4; i++) strobe(4'($urandom), 1'b0);
    DATAREADY = 1'b1;
    wait_bits("t6", 7, 100);
    snap();
    do_reset(1);
    @(negedge clk); #1;
    chk("t6_sck", 32'(MCU_SCK), 0);
    chk("t6_mosi", 32'(MCU_MOSI), 0);
    chk("t6_level", 32'(FIFO_LEVEL), 0);
    chk("t6_ovf", 32'(OVERFLOW), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_ss", 32'(ss_pulses - b_ss), 0);
    chk("t6_idle_no_sck", 32'(sck_total - b_sck), 1);
    for (int i = 0; i < 4; i++) strobe(4'($urandom), 1'b1);
    wait_ss("t6b", 200);
    chk("t6_expect_0123", 32'(exp_words[exp_rd]), 32'h0123);
    check_words("t6b", 1);
    check_hdrs("t6b", 1);

    // Randomized traffic with DATAREADY windows
    for (int w = 0; w < 12; w++) begin
      DATAREADY = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 2) == 0) strobe(4'($urandom), 1'($urandom_range(0, 1)));
        else begin
          @(posedge clk); #1;
        end
      end
    end
    DATAREADY = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check_words("rnd", exp_words.size() - exp_rd);
`ifdef GPS_BRIDGE_FRAME_HEADER_EN
    check_hdrs("rnd", hdr_words.size() - hdr_rd);
`endif
    chk("rnd_ovf", 32'(OVERFLOW), 32'(model_ovf));
    chk("rnd_level", 32'(FIFO_LEVEL), 0);
    chk("rnd_ss_width", 32'(ss_high), 32'(ss_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
